button_event_arbiter: RTL and testbench
=======================================

# button_event_arbiter

Collects the one-cycle button pulses produced by the per-button level-to-pulse converters and arbitrates them onto a single event channel for the sale-terminal main FSM. Simultaneous presses are served round-robin, and each event is queued in a small FIFO. Events are delivered over a valid/ready handshake, and no press is silently lost. The block sits between the button conditioning chain and the terminal controller.

## Interface
- NUM_BTN, 4: number of button inputs, 2..16.
- FIFO_DEPTH, 4: event queue depth, power of two, ≥2.
- REPEAT_DELAY, 50_000_000: hold cycles before the first auto-repeat event.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeat events.

- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- BtnPulse  in  NUM_BTN  one-cycle pulses, one bit per button.
- BtnLevel  in  NUM_BTN  clean debounced levels, active high; used only for auto-repeat.
- EventReady  in  1  consumer accepts the head event.
- ClearOverflow  in  1  synchronous clear of Overflow.
- EventValid  out  1  FIFO non-empty.
- EventCode  out  CW=clog2(NUM_BTN)  button index of the head event.
- EventRepeat  out  1  head event was generated by auto-repeat.
- Overflow  out  1  sticky flag: at least one press was dropped.

## Operation
- Reset values:
  - Outputs: EventValid=0, EventCode=0, EventRepeat=0, Overflow=0.
  - Internal state: pending=0, rr_ptr=0, FIFO empty, repeat counter=0.
- Pending register, one bit per button:
  - Set by BtnPulse[i], or by a repeat tick for button i.
  - Cleared when button i is granted.
- Grant:
  - A grant is issued when any pending bit is set AND the FIFO can accept (count<FIFO_DEPTH, or a pop happens this cycle).
  - The winner is the first pending index scanning upward from rr_ptr, with wrap-around.
  - After a grant, rr_ptr = (winner+1) mod NUM_BTN. rr_ptr holds when there is no grant.
- On grant, the FIFO pushes {repeat_flag, code}.
- Pop happens on EventValid & EventReady. EventCode and EventRepeat always show the head entry, and are 0 when the FIFO is empty.
- Boundary conditions:
  - Pulse on a button whose pending bit is set and not granted this cycle: the pulse is dropped and Overflow is set.
  - Pulse on the same cycle that button is granted: pending stays set, the new press is kept, and Overflow does not change.
  - FIFO full with no pop: pending bits are held and no grant is issued; nothing is lost until a second press arrives on the same button.
  - Push and pop on the same cycle while full: both happen and count is unchanged.
  - ClearOverflow on the same cycle as a new drop: Overflow stays 1 (set wins).
  - Repeat flag merging: if a real pulse and a repeat tick target a button whose pending bit is clear, repeat_flag=0. A repeat tick on a pending button is discarded without setting Overflow.
- RST_N asserted mid-operation: all state clears immediately, queued events are discarded, and outputs go to their reset values asynchronously.

## Timing
- Latency from pulse to event:
  - BtnPulse high at edge k sets pending at edge k.
  - The grant and push happen at edge k+1.
  - EventValid is high after edge k+1, i.e. 2 cycles, when the FIFO is not full.
- Throughput: one grant per cycle and one pop per cycle.
- N simultaneous pulses appear as N consecutive events, in round-robin order starting at rr_ptr.
- EventValid does not depend combinationally on EventReady. All outputs are registered or decoded from registered state.

## Configuration
- BUTTON_AUTO_REPEAT_EN defined:
  - The repeat target is the lowest-index asserted BtnLevel bit.
  - The counter restarts at 0 when the target changes or no level is asserted.
  - A repeat tick fires when the counter reaches REPEAT_DELAY−1, then every REPEAT_PERIOD cycles while the same target stays held.
- BUTTON_AUTO_REPEAT_EN undefined:
  - No counter is built, BtnLevel is ignored, and EventRepeat is constant 0.
  - The port list is unchanged.

## Structure
- Shared package holds:
  - The clog2 function.
  - The event entry width constant (CW+1).
  - The field positions of the repeat flag and code within an entry.
- Sub-module button_event_fifo: synchronous FIFO with WIDTH and DEPTH parameters. Ports push, pop, din, dout, count, empty, full; asynchronous active-low reset.
- Arbiter, pending register and repeat timer live in the top level.

## Test plan
- Single pulse on BtnPulse[2], EventReady=1 → EventValid high 2 cycles later for exactly 1 cycle, EventCode=2, EventRepeat=0.
- BtnPulse=4'b1011 in one cycle, rr_ptr=0, EventReady=1 → events with codes 0,1,3 on consecutive cycles; rr_ptr ends at 0.
- EventReady=0, pulses on buttons 0,1,2,3,0 (FIFO_DEPTH=4) → FIFO fills with 0,1,2,3. Button 0's second press stays pending. A further pulse on button 0 sets Overflow. Releasing EventReady drains 0,1,2,3,0.
- BUTTON_AUTO_REPEAT_EN with REPEAT_DELAY=10, REPEAT_PERIOD=4, BtnLevel[1] held 25 cycles → repeat events for code 1 with EventRepeat=1 at hold cycles 10, 14, 18, 22.
- RST_N pulsed low while 3 events are queued and Overflow=1 → EventValid and Overflow go 0 immediately; the next pulse on button 3 yields code 3 as the first event.

Source files
------------

// File: rtl/button_event_arbiter_pkg.sv
// Shared sizing helpers and event-entry layout for the button event arbiter.
package button_event_arbiter_pkg;

  localparam int CODE_LSB = 32'sd0;

  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  // Entry = {repeat_flag, code}; the flag sits just above the code field.
  function automatic int entryWidth(input int numBtn);
    return clog2(numBtn) + 32'sd1;
  endfunction

  function automatic int repeatPos(input int numBtn);
    return clog2(numBtn);
  endfunction

endpackage

// File: rtl/button_event_fifo.sv
// Small synchronous FIFO; dout shows the head entry and reads as zero when empty.
module button_event_fifo
  import button_event_arbiter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [clog2(DEPTH):0]   count,
  output logic                    empty,
  output logic                    full
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wrPtr_r, rdPtr_r;
  logic [AW:0]      count_r;
  logic             doPush_s, doPop_s;

  assign empty    = (count_r == '0);
  assign full     = (count_r == (AW+1)'(DEPTH));
  assign count    = count_r;
  assign doPop_s  = pop & ~empty;
  assign doPush_s = push & (~full | doPop_s);
  assign dout     = empty ? '0 : mem_r[rdPtr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else begin
      if (doPush_s) begin
        mem_r[wrPtr_r] <= din;
        wrPtr_r        <= wrPtr_r + 1'b1;
      end else begin
        wrPtr_r <= wrPtr_r;
      end
      if (doPop_s) begin
        rdPtr_r <= rdPtr_r + 1'b1;
      end else begin
        rdPtr_r <= rdPtr_r;
      end
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter merging per-button pulses into one queued event stream.
// Optional auto-repeat of the lowest held button: define BUTTON_AUTO_REPEAT_EN.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int NUM_BTN       = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [NUM_BTN-1:0]         BtnPulse,
  input  logic [NUM_BTN-1:0]         BtnLevel,
  input  logic                       EventReady,
  input  logic                       ClearOverflow,
  output logic                       EventValid,
  output logic [clog2(NUM_BTN)-1:0]  EventCode,
  output logic                       EventRepeat,
  output logic                       Overflow
);
  localparam int CW      = clog2(NUM_BTN);
  localparam int EW      = entryWidth(NUM_BTN);
  localparam int REP_POS = repeatPos(NUM_BTN);

  logic [NUM_BTN-1:0]         pending_r, pendingRep_r, pendingNext_s, pendingRepNext_s;
  logic [NUM_BTN-1:0]         grantOneHot_s, drop_s, repTick_s;
  logic [CW-1:0]              rrPtr_r, winner_s;
  logic                       grant_s, pop_s, fifoEmpty_s, fifoFull_s, anyPending_s;
  logic [EW-1:0]              pushEntry_s, headEntry_s;
  logic [clog2(FIFO_DEPTH):0] unusedCount_s;

  assign EventValid = ~fifoEmpty_s;
  assign pop_s      = EventValid & EventReady;
  assign EventCode  = headEntry_s[CODE_LSB +: CW];

  // First pending button at or above rrPtr_r, wrapping around.
  always_comb begin
    int idx;
    winner_s     = '0;
    anyPending_s = 1'b0;
    idx          = 32'sd0;
    for (int k = 0; k < NUM_BTN; k++) begin
      idx = (int'(rrPtr_r) + k) % NUM_BTN;
      if (!anyPending_s && pending_r[idx]) begin
        winner_s     = CW'(idx);
        anyPending_s = 1'b1;
      end else begin
      end
    end
    grant_s = anyPending_s & (~fifoFull_s | pop_s);
  end

  // Pending update: a granted button may re-arm from a same-cycle press.
  always_comb begin
    grantOneHot_s    = '0;
    pendingNext_s    = pending_r;
    pendingRepNext_s = pendingRep_r;
    drop_s           = '0;
    pushEntry_s      = '0;
    if (grant_s) begin
      grantOneHot_s[winner_s] = 1'b1;
    end else begin
      grantOneHot_s = '0;
    end
    pushEntry_s[CODE_LSB +: CW] = winner_s;
    pushEntry_s[REP_POS]        = pendingRep_r[winner_s];
    for (int i = 0; i < NUM_BTN; i++) begin
      if (grantOneHot_s[i]) begin
        pendingNext_s[i]    = BtnPulse[i];
        pendingRepNext_s[i] = 1'b0;
      end else if (pending_r[i]) begin
        drop_s[i] = BtnPulse[i];
      end else begin
        pendingNext_s[i]    = BtnPulse[i] | repTick_s[i];
        pendingRepNext_s[i] = repTick_s[i] & ~BtnPulse[i];
      end
    end
  end

  // Pending bits, round-robin pointer and sticky overflow (set beats clear).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending_r    <= '0;
      pendingRep_r <= '0;
      rrPtr_r      <= '0;
      Overflow     <= 1'b0;
    end else begin
      pending_r    <= pendingNext_s;
      pendingRep_r <= pendingRepNext_s;
      if (grant_s) begin
        rrPtr_r <= CW'((int'(winner_s) + 32'sd1) % NUM_BTN);
      end else begin
        rrPtr_r <= rrPtr_r;
      end
      if (|drop_s) begin
        Overflow <= 1'b1;
      end else if (ClearOverflow) begin
        Overflow <= 1'b0;
      end else begin
        Overflow <= Overflow;
      end
    end
  end

  button_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (grant_s),
    .pop   (pop_s),
    .din   (pushEntry_s),
    .dout  (headEntry_s),
    .count (unusedCount_s),
    .empty (fifoEmpty_s),
    .full  (fifoFull_s)
  );

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int CNTW = clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 32'sd1);

  logic [CNTW-1:0] repCnt_r, effCnt_s, limit_s;
  logic [CW-1:0]   repTarget_r, target_s;
  logic            repActive_r, repeating_r, anyLevel_s, restart_s, tick_s;

  // Counter value for this cycle is zero whenever the held target just changed.
  always_comb begin
    target_s   = '0;
    anyLevel_s = 1'b0;
    repTick_s  = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (BtnLevel[i]) begin
        target_s   = CW'(i);
        anyLevel_s = 1'b1;
      end else begin
      end
    end
    restart_s = ~repActive_r | (target_s != repTarget_r);
    effCnt_s  = restart_s ? '0 : repCnt_r;
    limit_s   = (repeating_r && !restart_s) ? CNTW'(REPEAT_PERIOD - 1) : CNTW'(REPEAT_DELAY - 1);
    tick_s    = anyLevel_s & (effCnt_s == limit_s);
    if (tick_s) begin
      repTick_s[target_s] = 1'b1;
    end else begin
      repTick_s = '0;
    end
  end

  // Hold-time counter: initial delay, then the shorter repeat period.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      repCnt_r    <= '0;
      repTarget_r <= '0;
      repActive_r <= 1'b0;
      repeating_r <= 1'b0;
    end else if (!anyLevel_s) begin
      repCnt_r    <= '0;
      repTarget_r <= '0;
      repActive_r <= 1'b0;
      repeating_r <= 1'b0;
    end else begin
      repActive_r <= 1'b1;
      repTarget_r <= target_s;
      if (tick_s) begin
        repCnt_r    <= '0;
        repeating_r <= 1'b1;
      end else begin
        repCnt_r    <= effCnt_s + 1'b1;
        repeating_r <= repeating_r & ~restart_s;
      end
    end
  end

  assign EventRepeat = headEntry_s[REP_POS];
`else
  logic unusedRepeat_s;

  assign repTick_s      = '0;
  assign EventRepeat    = 1'b0;
  assign unusedRepeat_s = ^{BtnLevel, headEntry_s[REP_POS], REPEAT_DELAY, REPEAT_PERIOD};
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter; repeat scenario active with BUTTON_AUTO_REPEAT_EN.
module tb_button_event_arbiter;
  localparam int NB = 4;
  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [NB-1:0] BtnPulse, BtnLevel;
  logic          EventReady, ClearOverflow;
  logic          EventValid, EventRepeat, Overflow;
  logic [CW-1:0] EventCode;

  logic [CW:0]   expQ [$];
  logic [CW:0]   expE;
  int            checks = 0;
  int            errors = 0;

  button_event_arbiter #(
    .NUM_BTN       (NB),
    .FIFO_DEPTH    (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (4)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .BtnPulse      (BtnPulse),
    .BtnLevel      (BtnLevel),
    .EventReady    (EventReady),
    .ClearOverflow (ClearOverflow),
    .EventValid    (EventValid),
    .EventCode     (EventCode),
    .EventRepeat   (EventRepeat),
    .Overflow      (Overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic resetDut();
    RST_N = 1'b0;
    BtnPulse = '0;
    BtnLevel = '0;
    EventReady = 1'b1;
    ClearOverflow = 1'b0;
    expQ.delete();
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((EventValid || expQ.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    check({name, "_queue_empty"}, expQ.size(), 0);
    check({name, "_valid_low"}, EventValid, 1'b0);
  endtask

  // Monitor: every accepted event is compared against the scoreboard head.
  always @(negedge CLK) begin
    if (RST_N && EventValid && EventReady) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got code %0d repeat %0d, expected no event", EventCode, EventRepeat);
      end else begin
        expE = expQ.pop_front();
        check("event_code", EventCode, expE[CW-1:0]);
        check("event_repeat", EventRepeat, expE[CW]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    BtnPulse = '0;
    BtnLevel = '0;
    EventReady = 1'b1;
    ClearOverflow = 1'b0;
    tick();
    tick();
    check("reset_valid", EventValid, 1'b0);
    check("reset_code", EventCode, 0);
    check("reset_repeat", EventRepeat, 1'b0);
    check("reset_overflow", Overflow, 1'b0);
    RST_N = 1'b1;
    tick();

    // Single pulse: valid two edges later, for exactly one cycle.
    BtnPulse = 4'b0100;
    expQ.push_back({1'b0, 2'd2});
    tick();
    BtnPulse = '0;
    check("single_valid_k", EventValid, 1'b0);
    tick();
    check("single_valid_k1", EventValid, 1'b1);
    check("single_code", EventCode, 2);
    tick();
    check("single_valid_k2", EventValid, 1'b0);
    waitDrain("single");

    // Simultaneous presses served round-robin from rr_ptr=0.
    resetDut();
    BtnPulse = 4'b1011;
    expQ.push_back({1'b0, 2'd0});
    expQ.push_back({1'b0, 2'd1});
    expQ.push_back({1'b0, 2'd3});
    tick();
    BtnPulse = '0;
    check("rr_valid_k", EventValid, 1'b0);
    tick();
    check("rr_code_0", EventCode, 0);
    tick();
    check("rr_code_1", EventCode, 1);
    tick();
    check("rr_code_3", EventCode, 3);
    tick();
    check("rr_done", EventValid, 1'b0);
    waitDrain("rr1011");

    // rr_ptr back at 0: all four come out 0,1,2,3.
    BtnPulse = 4'b1111;
    for (int i = 0; i < 4; i++) expQ.push_back({1'b0, CW'(i)});
    tick();
    BtnPulse = '0;
    waitDrain("rr1111");

    // Grant of 1 moves rr_ptr to 2, so 2 beats 0 next.
    BtnPulse = 4'b0010;
    expQ.push_back({1'b0, 2'd1});
    tick();
    BtnPulse = '0;
    waitDrain("rr_prep");
    BtnPulse = 4'b0101;
    expQ.push_back({1'b0, 2'd2});
    expQ.push_back({1'b0, 2'd0});
    tick();
    BtnPulse = '0;
    waitDrain("rr_wrap");

    // Fill FIFO with ready low; fifth press waits in pending.
    resetDut();
    EventReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      BtnPulse = 4'b0001 << (i % 4);
      expQ.push_back({1'b0, CW'(i % 4)});
      tick();
    end
    BtnPulse = '0;
    tick();
    tick();
    check("full_valid", EventValid, 1'b1);
    check("full_head", EventCode, 0);
    check("full_no_overflow", Overflow, 1'b0);
    BtnPulse = 4'b0001;
    tick();
    check("full_drop_overflow", Overflow, 1'b1);
    ClearOverflow = 1'b1;
    tick();
    check("clear_vs_drop", Overflow, 1'b1);
    BtnPulse = '0;
    tick();
    check("clear_overflow", Overflow, 1'b0);
    ClearOverflow = 1'b0;
    EventReady = 1'b1;
    waitDrain("full_drain");

    // Asynchronous reset with queued events and overflow set.
    resetDut();
    EventReady = 1'b0;
    BtnPulse = 4'b0111;
    tick();
    BtnPulse = 4'b0010;
    tick();
    BtnPulse = '0;
    tick();
    tick();
    check("pre_reset_overflow", Overflow, 1'b1);
    check("pre_reset_valid", EventValid, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset_valid", EventValid, 1'b0);
    check("async_reset_overflow", Overflow, 1'b0);
    check("async_reset_code", EventCode, 0);
    expQ.delete();
    #1;
    RST_N = 1'b1;
    tick();
    EventReady = 1'b1;
    BtnPulse = 4'b1000;
    expQ.push_back({1'b0, 2'd3});
    tick();
    BtnPulse = '0;
    waitDrain("post_reset");

    // Hold button 1 for 25 cycles.
    resetDut();
`ifdef BUTTON_AUTO_REPEAT_EN
    for (int i = 0; i < 4; i++) expQ.push_back({1'b1, 2'd1});
`endif
    BtnLevel = 4'b0010;
    repeat (25) tick();
    BtnLevel = '0;
    waitDrain("auto_repeat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
